// File: rtl/switch_ingress_arb.sv
// rtl/switch_ingress_arb.sv - packet-granular round-robin arbiter for the switch core ingress write port (optional stats: SWITCH_INGRESS_ARB_STATS_EN)
module switch_ingress_arb #(
    parameter int NPORT     = 4,
    parameter int MAX_BEATS = 96
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [16*NPORT-1:0]  in_desc,
    input  logic [NPORT-1:0]     in_desc_vld,
    output logic [NPORT-1:0]     in_desc_rdy,
    input  logic [128*NPORT-1:0] in_data,
    input  logic [NPORT-1:0]     in_data_vld,
    output logic [NPORT-1:0]     in_data_rdy,
    output logic [127:0]         o_cell_data_fifo_din,
    output logic                 o_cell_data_fifo_wr,
    output logic [15:0]          o_cell_ptr_fifo_din,
    output logic                 o_cell_ptr_fifo_wr,
    input  logic                 i_cell_bp,
    output logic [NPORT-1:0]     o_grant,
`ifdef SWITCH_INGRESS_ARB_STATS_EN
    output logic [16*NPORT-1:0]  o_pkt_cnt,
    output logic [15:0]          o_drop_cnt,
`endif
    output logic                 o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_PTR  = 2'd3
    } state_t;

    localparam logic [7:0]       LP_MAX = 8'(MAX_BEATS);
    localparam logic [NPORT-1:0] LP_ONE = 1;

    state_t             r_state;
    logic [1:0]         r_rr;
    logic [1:0]         r_gidx;
    logic [NPORT-1:0]   r_grant;
    logic [15:0]        r_desc;
    logic [7:0]         r_cnt;
    logic [127:0]       r_data_din;
    logic               r_data_wr;
    logic [15:0]        r_ptr_din;
    logic               r_ptr_wr;
    logic               r_drop;

    logic               w_found;
    logic [1:0]         w_win;
    logic [1:0]         w_idx;
    logic               w_start;
    logic [15:0]        w_desc_sel;
    logic [7:0]         w_len;
    logic [127:0]       w_beat;
    logic               w_beat_acc;
    logic               w_last;

    // Round-robin search: first requesting port at or after the RR pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr;
        w_idx   = r_rr;
        for (int i = 0; i < NPORT; i++) begin
            w_idx = r_rr + 2'(i);
            if (!w_found && in_desc_vld[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_start    = (r_state == ST_IDLE) && w_found && !i_cell_bp;
    assign w_desc_sel = in_desc[{w_win, 4'b0000} +: 16];
    assign w_len      = w_desc_sel[7:0];
    assign w_beat     = in_data[{r_gidx, 7'b0000000} +: 128];
    assign w_beat_acc = |(in_data_vld & in_data_rdy);
    assign w_last     = (r_cnt + 8'd1) == r_desc[7:0];

    // Descriptor accept is offered to the round-robin winner only, for one cycle.
    always_comb begin
        in_desc_rdy = '0;
        if (w_start) begin
            in_desc_rdy = LP_ONE << w_win;
        end
    end

    // Beat accept: granted port only; bp gates real data but not discarded beats.
    always_comb begin
        in_data_rdy = '0;
        case (r_state)
            ST_DATA: in_data_rdy = i_cell_bp ? '0 : r_grant;
            ST_DROP: in_data_rdy = r_grant;
            default: in_data_rdy = '0;
        endcase
    end

    // Packet FSM with registered core-side strobes; pointer always trails the last data write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rr       <= 2'd0;
            r_gidx     <= 2'd0;
            r_grant    <= '0;
            r_desc     <= 16'd0;
            r_cnt      <= 8'd0;
            r_data_din <= 128'd0;
            r_data_wr  <= 1'b0;
            r_ptr_din  <= 16'd0;
            r_ptr_wr   <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_data_wr <= 1'b0;
            r_ptr_wr  <= 1'b0;
            r_drop    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_desc <= w_desc_sel;
                        r_gidx <= w_win;
                        r_cnt  <= 8'd0;
                        if (w_len == 8'd0) begin
                            r_drop <= 1'b1;
                            r_rr   <= w_win + 2'd1;
                        end else begin
                            r_grant <= LP_ONE << w_win;
                            r_state <= (w_len > LP_MAX) ? ST_DROP : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_beat_acc) begin
                        r_data_din <= w_beat;
                        r_data_wr  <= 1'b1;
                        r_cnt      <= r_cnt + 8'd1;
                        if (w_last) begin
                            r_state <= ST_PTR;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_beat_acc) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last) begin
                            r_drop  <= 1'b1;
                            r_rr    <= r_gidx + 2'd1;
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_PTR: begin
                    r_ptr_wr  <= 1'b1;
                    r_ptr_din <= r_desc;
                    r_rr      <= r_gidx + 2'd1;
                    r_grant   <= '0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cell_data_fifo_din = r_data_din;
    assign o_cell_data_fifo_wr  = r_data_wr;
    assign o_cell_ptr_fifo_din  = r_ptr_din;
    assign o_cell_ptr_fifo_wr   = r_ptr_wr;
    assign o_grant              = r_grant;
    assign o_drop               = r_drop;

`ifdef SWITCH_INGRESS_ARB_STATS_EN
    logic [15:0] r_pkt_cnt [NPORT];
    logic [15:0] r_drop_cnt;

    // Saturating per-port completed-packet and total-drop counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NPORT; i++) begin
                r_pkt_cnt[i] <= 16'd0;
            end
            r_drop_cnt <= 16'd0;
        end else begin
            if (r_state == ST_PTR && r_pkt_cnt[r_gidx] != 16'hFFFF) begin
                r_pkt_cnt[r_gidx] <= r_pkt_cnt[r_gidx] + 16'd1;
            end
            if (r_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_pkt_cnt
        assign o_pkt_cnt[16*g +: 16] = r_pkt_cnt[g];
    end
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_switch_ingress_arb.sv
// tb/tb_switch_ingress_arb.sv - scoreboard bench for switch_ingress_arb
module tb_switch_ingress_arb;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [63:0]    in_desc = '0;
    logic [3:0]     in_desc_vld = '0;
    logic [3:0]     in_desc_rdy;
    logic [511:0]   in_data = '0;
    logic [3:0]     in_data_vld = '0;
    logic [3:0]     in_data_rdy;
    logic [127:0]   o_cell_data_fifo_din;
    logic           o_cell_data_fifo_wr;
    logic [15:0]    o_cell_ptr_fifo_din;
    logic           o_cell_ptr_fifo_wr;
    logic           i_cell_bp = 1'b0;
    logic [3:0]     o_grant;
    logic           o_drop;
`ifdef SWITCH_INGRESS_ARB_STATS_EN
    logic [63:0]    o_pkt_cnt;
    logic [15:0]    o_drop_cnt;
`endif

    switch_ingress_arb dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .in_desc              (in_desc),
        .in_desc_vld          (in_desc_vld),
        .in_desc_rdy          (in_desc_rdy),
        .in_data              (in_data),
        .in_data_vld          (in_data_vld),
        .in_data_rdy          (in_data_rdy),
        .o_cell_data_fifo_din (o_cell_data_fifo_din),
        .o_cell_data_fifo_wr  (o_cell_data_fifo_wr),
        .o_cell_ptr_fifo_din  (o_cell_ptr_fifo_din),
        .o_cell_ptr_fifo_wr   (o_cell_ptr_fifo_wr),
        .i_cell_bp            (i_cell_bp),
        .o_grant              (o_grant),
`ifdef SWITCH_INGRESS_ARB_STATS_EN
        .o_pkt_cnt            (o_pkt_cnt),
        .o_drop_cnt           (o_drop_cnt),
`endif
        .o_drop               (o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] desc;
        int          cum;
    } ptr_t;

    logic [15:0]  q_desc [4][$];
    logic [127:0] q_beat [4][$];
    logic [127:0] exp_data [$];
    ptr_t         exp_ptr [$];
    int           exp_grant [$];

    int checks = 0;
    int errors = 0;
    int data_seen = 0;
    int drops_seen = 0;
    int exp_drops = 0;
    int exp_data_total = 0;
    int pkt_id = 0;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // keep < 0: whole legal packet expected; keep >= 0: only that many data writes, no pointer.
    task automatic push_pkt(input int p, input logic [15:0] desc, input int keep);
        int len;
        int nexp;
        logic [127:0] b;
        ptr_t e;
        len = int'(desc[7:0]);
        nexp = (keep < 0) ? len : keep;
        pkt_id++;
        q_desc[p].push_back(desc);
        if (len == 0) begin
            exp_drops++;
        end else begin
            exp_grant.push_back(p);
            if (len > 96) exp_drops++;
        end
        for (int i = 0; i < len; i++) begin
            b = {8'(p), 8'(pkt_id), 16'(i), 32'($urandom), $urandom, $urandom};
            q_beat[p].push_back(b);
            if (len <= 96 && i < nexp) begin
                exp_data.push_back(b);
                exp_data_total++;
            end
        end
        if (len > 0 && len <= 96 && keep < 0) begin
            e.desc = desc;
            e.cum  = exp_data_total;
            exp_ptr.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && (q_desc[0].size() + q_desc[1].size() + q_desc[2].size() + q_desc[3].size()
               + q_beat[0].size() + q_beat[1].size() + q_beat[2].size() + q_beat[3].size()
               + exp_data.size() + exp_ptr.size() + exp_grant.size()) != 0) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("idle_timeout", n < budget, 1'b1);
        repeat (3) @(negedge clk);
        #2;
    endtask

    // Requester model: present queue heads at negedge, pop on handshake at the following posedge.
    always begin : drv
        logic [3:0] dacc;
        logic [3:0] bacc;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            in_desc_vld[p]       = q_desc[p].size() != 0;
            in_desc[16*p +: 16]  = in_desc_vld[p] ? q_desc[p][0] : 16'd0;
            in_data_vld[p]       = q_beat[p].size() != 0;
            in_data[128*p +: 128] = in_data_vld[p] ? q_beat[p][0] : 128'd0;
        end
        #4;
        dacc = in_desc_vld & in_desc_rdy;
        bacc = in_data_vld & in_data_rdy;
        @(posedge clk);
        for (int p = 0; p < 4; p++) begin
            if (dacc[p]) void'(q_desc[p].pop_front());
            if (bacc[p]) void'(q_beat[p].pop_front());
        end
    end

    // Core-side monitor against the scoreboard.
    always @(negedge clk) begin : mon
        ptr_t e;
        int gp;
        if (o_cell_data_fifo_wr) begin
            if (exp_data.size() == 0) chk("unexpected_data_wr", 1'b1, 1'b0);
            else chk("data_din", o_cell_data_fifo_din, exp_data.pop_front());
            data_seen++;
        end
        if (o_cell_ptr_fifo_wr) begin
            chk("ptr_not_with_data", o_cell_data_fifo_wr, 1'b0);
            if (exp_ptr.size() == 0) chk("unexpected_ptr_wr", 1'b1, 1'b0);
            else begin
                e = exp_ptr.pop_front();
                chk("ptr_din", o_cell_ptr_fifo_din, e.desc);
                chk("ptr_after_data", data_seen, e.cum);
            end
        end
        if (o_drop) drops_seen++;
        if (o_grant != 4'd0 && prev_grant == 4'd0) begin
            if (exp_grant.size() == 0) chk("unexpected_grant", o_grant, 4'd0);
            else begin
                gp = exp_grant.pop_front();
                chk("grant", o_grant, 4'd1 << gp);
            end
        end
        chk("data_rdy_ungranted", in_data_rdy & ~o_grant, 4'd0);
        prev_grant = o_grant;
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, o_grant, 4'd0);
        chk({tag, "_data_wr"}, o_cell_data_fifo_wr, 1'b0);
        chk({tag, "_ptr_wr"}, o_cell_ptr_fifo_wr, 1'b0);
        chk({tag, "_drop"}, o_drop, 1'b0);
        chk({tag, "_desc_rdy"}, in_desc_rdy, 4'd0);
        chk({tag, "_data_rdy"}, in_data_rdy, 4'd0);
    endtask

    initial begin : stim
        int base;
        int n;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk_quiet("reset");
        chk("reset_data_din", o_cell_data_fifo_din, 128'd0);
        chk("reset_ptr_din", o_cell_ptr_fifo_din, 16'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single packet on port 2
        push_pkt(2, 16'h0108, -1);
        wait_idle(200);
        chk("single_data_count", data_seen, 8);

        // Round robin from a fresh pointer: 0,1,2,3,0
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        push_pkt(0, 16'h0E04, -1);
        push_pkt(1, 16'h0D04, -1);
        push_pkt(2, 16'h0B04, -1);
        push_pkt(3, 16'h0704, -1);
        push_pkt(0, 16'h0F04, -1);
        wait_idle(400);
        chk("rr_data_count", data_seen, 28);

        // Backpressure holds off the descriptor, then stalls mid-packet
        i_cell_bp = 1'b1;
        push_pkt(0, 16'h0308, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_desc_rdy", in_desc_rdy, 4'd0);
        end
        i_cell_bp = 1'b0;
        base = data_seen;
        n = 0;
        while (data_seen < base + 3 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("bp_wait_beat3", n < 50, 1'b1);
        i_cell_bp = 1'b1;
        repeat (5) @(negedge clk);
        i_cell_bp = 1'b0;
        wait_idle(200);
        chk("bp_data_count", data_seen - base, 8);

        // Zero-length drop: pulse, no core writes
        base = data_seen;
        push_pkt(1, 16'h0100, -1);
        wait_idle(100);
        chk("drop0_no_writes", data_seen, base);
        chk("drop0_pulses", drops_seen, exp_drops);

        // Oversize drop on port 2 followed by a legal packet on port 3
        base = data_seen;
        push_pkt(2, 16'h0264, -1);
        push_pkt(3, 16'h0805, -1);
        wait_idle(400);
        chk("drop100_pulses", drops_seen, exp_drops);
        chk("drop100_next_port", data_seen - base, 5);

        // Reset after the second beat of a 6-beat packet
        base = data_seen;
        push_pkt(0, 16'h0206, 2);
        n = 0;
        while (data_seen < base + 2 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("rst_wait_beat2", n < 50, 1'b1);
        rstn = 1'b0;
        #1;
        chk_quiet("midrst");
        q_desc[0].delete();
        q_beat[0].delete();
        repeat (2) @(negedge clk);
        #2;
        chk_quiet("midrst_hold");
        @(negedge clk);
        rstn = 1'b1;
        push_pkt(0, 16'h0103, -1);
        wait_idle(200);
        chk("rst_recover_count", data_seen - base, 5);

`ifdef SWITCH_INGRESS_ARB_STATS_EN
        // Stats: three packets and one drop on port 1
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        push_pkt(1, 16'h0102, -1);
        push_pkt(1, 16'h0103, -1);
        push_pkt(1, 16'h0100, -1);
        push_pkt(1, 16'h0101, -1);
        wait_idle(200);
        chk("stats_pkt_p1", o_pkt_cnt[31:16], 16'd3);
        chk("stats_pkt_others", {o_pkt_cnt[63:32], o_pkt_cnt[15:0]}, 48'd0);
        chk("stats_drop", o_drop_cnt, 16'd1);
`endif

        chk("final_drop_pulses", drops_seen, exp_drops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
